// File: rtl/gpio_debounce_events_pkg.sv
// gpio_debounce_events_pkg
// Shared constants and helpers for the GPIO debounce/event block.
//   DefaultSyncN : default synchroniser depth in flops
//   HoldCntW     : width of the per-channel long-press hold counter
//   prescWidth() : prescaler counter width for a given RATE, never below 1
package gpio_debounce_events_pkg;

  localparam int unsigned DefaultSyncN = 2;
  localparam int unsigned HoldCntW     = 16;

  // A RATE of 1 or 2 still needs one counter bit, so clamp the result of $clog2 to at least 1.
  function automatic int unsigned prescWidth(input int unsigned rate);
    prescWidth = (rate <= 2) ? 1 : $clog2(rate);
  endfunction

endpackage

// File: rtl/gpio_debounce_channel.sv
// gpio_debounce_channel
// Debounce and event logic for one GPIO channel, fed by an already
// synchronised sample and the shared sample tick.
// Optional long-press detection is built when GPIO_DEBOUNCE_LONG_PRESS_EN
// is defined; otherwise long_press_o is tied to 0 and no counter exists.
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   tick_i       : one-cycle sample strobe from the shared prescaler
//   sample_i     : synchronised, polarity-corrected input bit
//   evt_clr_i    : synchronous level clear of the sticky event flag
//   out_o        : debounced level
//   rise_o       : one-cycle pulse on a 0->1 change of out_o
//   fall_o       : one-cycle pulse on a 1->0 change of out_o
//   evt_o        : sticky rise-event flag
//   long_press_o : one-cycle pulse after LONG_TICKS ticks of held-high level
module gpio_debounce_channel
  import gpio_debounce_events_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LONG_TICKS = 2000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic sample_i,
  input  logic evt_clr_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o,
  output logic long_press_o
);

  logic [N-1:0] shiftQ;
  logic         shiftedQ;
  logic         outQ, outD;
  logic         riseQ, riseD;
  logic         fallQ, fallD;
  logic         evtQ, evtD;
  logic         allOnes, allZeros;

  assign allOnes  = &shiftQ;
  assign allZeros = ~|shiftQ;

  // The level decision looks at the shift register one edge after it
  // shifted (shiftedQ), so out and the rise/fall pulses change together.
  // The sticky flag is set from the registered rise pulse; the set term is
  // ORed last so a clear in the same cycle cannot win.
  always_comb begin
    outD  = outQ;
    riseD = 1'b0;
    fallD = 1'b0;
    if (shiftedQ && allOnes) begin
      outD  = 1'b1;
      riseD = ~outQ;
    end else if (shiftedQ && allZeros) begin
      outD  = 1'b0;
      fallD = outQ;
    end
    evtD = riseQ | (evtQ & ~evt_clr_i);
  end

  // Sample shift register plus the registered level, edge and event state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shiftQ   <= '0;
      shiftedQ <= 1'b0;
      outQ     <= 1'b0;
      riseQ    <= 1'b0;
      fallQ    <= 1'b0;
      evtQ     <= 1'b0;
    end else begin
      if (tick_i) begin
        shiftQ <= {shiftQ[N-2:0], sample_i};
      end
      shiftedQ <= tick_i;
      outQ     <= outD;
      riseQ    <= riseD;
      fallQ    <= fallD;
      evtQ     <= evtD;
    end
  end

  assign out_o  = outQ;
  assign rise_o = riseQ;
  assign fall_o = fallQ;
  assign evt_o  = evtQ;

`ifdef GPIO_DEBOUNCE_LONG_PRESS_EN
  localparam logic [HoldCntW-1:0] HoldTarget = HoldCntW'(LONG_TICKS);

  logic [HoldCntW-1:0] holdQ, holdD;
  logic                longQ, longD;

  // Hold counter: cleared while the level is low, counts ticks while high
  // and stops at the target so the pulse fires only once per press.
  always_comb begin
    holdD = holdQ;
    longD = 1'b0;
    if (!outQ) begin
      holdD = '0;
    end else if (tick_i && (holdQ != HoldTarget)) begin
      holdD = holdQ + 1'b1;
      longD = (holdD == HoldTarget);
    end
  end

  // Registered hold count and long-press pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdQ <= '0;
      longQ <= 1'b0;
    end else begin
      holdQ <= holdD;
      longQ <= longD;
    end
  end

  assign long_press_o = longQ;
`else
  logic unusedLongTicks;
  assign unusedLongTicks = ^LONG_TICKS;
  assign long_press_o    = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce_events.sv
// gpio_debounce_events
// Synchronise, debounce and generate events for WIDTH GPIO inputs.
// Optional feature macro: GPIO_DEBOUNCE_LONG_PRESS_EN (long-press pulses).
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   in         : raw asynchronous pin inputs
//   out        : debounced levels
//   rise       : one-cycle pulses on 0->1 of out
//   fall       : one-cycle pulses on 1->0 of out
//   evt        : sticky rise-event flags
//   evt_clr    : per-bit synchronous clear of evt
//   long_press : one-cycle long-hold pulses (0 when feature is disabled)
module gpio_debounce_events
  import gpio_debounce_events_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       SYNC_N     = DefaultSyncN,
  parameter int unsigned       N          = 4,
  parameter int unsigned       RATE       = 125000,
  parameter logic [WIDTH-1:0]  INVERT     = {WIDTH{1'b0}},
  parameter int unsigned       LONG_TICKS = 2000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] long_press
);

  localparam int unsigned     CntW    = prescWidth(RATE);
  localparam logic [CntW-1:0] CntLast = CntW'(RATE - 1);

  logic [SYNC_N-1:0][WIDTH-1:0] syncQ;
  logic [CntW-1:0]              cntQ, cntD;
  logic                         tick;

  // Synchroniser chain; polarity is corrected before the first stage so
  // everything downstream sees the logical level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncQ <= '0;
    end else begin
      syncQ[0] <= in ^ INVERT;
      for (int s = 1; s < SYNC_N; s++) begin
        syncQ[s] <= syncQ[s-1];
      end
    end
  end

  // Shared prescaler; with RATE=1 the counter sits at 0 and tick is constant 1.
  assign tick = (cntQ == CntLast);
  assign cntD = tick ? '0 : cntQ + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : gChan
    gpio_debounce_channel #(
      .N          (N),
      .LONG_TICKS (LONG_TICKS)
    ) uChan (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_i       (tick),
      .sample_i     (syncQ[SYNC_N-1][g]),
      .evt_clr_i    (evt_clr[g]),
      .out_o        (out[g]),
      .rise_o       (rise[g]),
      .fall_o       (fall[g]),
      .evt_o        (evt[g]),
      .long_press_o (long_press[g])
    );
  end

endmodule

// File: tb/tb_gpio_debounce_events.sv
// tb_gpio_debounce_events
// Scoreboard bench for gpio_debounce_events (WIDTH=2, SYNC_N=2, N=3, RATE=4,
// LONG_TICKS=5) plus a second instance with INVERT=2'b01.
// Long-press checks adapt to GPIO_DEBOUNCE_LONG_PRESS_EN.
module tb_gpio_debounce_events;

  localparam int unsigned W  = 2;
  localparam int unsigned SN = 2;
  localparam int unsigned NN = 3;
  localparam int unsigned RT = 4;
  localparam int unsigned LT = 5;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] pins    = '0;
  logic [W-1:0] evtClr  = '0;
  logic [W-1:0] dout, rise, fall, evt, longPress;

  logic [W-1:0] invPins = '0;
  logic [W-1:0] invClr  = '0;
  logic [W-1:0] invOut, invRise, invFall, invEvt, invLong;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expT;
  expT expQ[$];

  int  lat, cnt, cnt2, riseCnt, fallCnt;
  bit  seen, seen2, flagA, flagB;
  logic [W-1:0] riseSnap;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  gpio_debounce_events #(
    .WIDTH(W), .SYNC_N(SN), .N(NN), .RATE(RT), .INVERT(2'b00), .LONG_TICKS(LT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(pins), .out(dout), .rise(rise),
    .fall(fall), .evt(evt), .evt_clr(evtClr), .long_press(longPress)
  );

  gpio_debounce_events #(
    .WIDTH(W), .SYNC_N(SN), .N(NN), .RATE(RT), .INVERT(2'b01), .LONG_TICKS(LT)
  ) dutInv (
    .clk(clk), .reset_n(reset_n), .in(invPins), .out(invOut), .rise(invRise),
    .fall(invFall), .evt(invEvt), .evt_clr(invClr), .long_press(invLong)
  );

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Expected values are queued when the stimulus is driven.
  task automatic pushExpected(input string tag, input logic [31:0] value);
    expT e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT produced.
  task automatic popCheck(input logic [31:0] observed);
    expT e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", expQ.size(), 1);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, observed, e.value);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic [W-1:0] value);
    @(negedge clk);
    pins = value;
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Hard time bound in case something stalls outside the cycle-bounded loops.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) stepCycle();
    pushExpected("rstOut", 0);
    pushExpected("rstPulses", 0);
    pushExpected("rstEvt", 0);
    pushExpected("rstLong", 0);
    popCheck(dout);
    popCheck(rise | fall);
    popCheck(evt);
    popCheck(longPress);
    @(negedge clk);
    reset_n = 1'b1;

    // Inversion instance settles to 01 from all-zero pins; main stays idle
    pushExpected("invOut", 2'b01);
    pushExpected("invRiseCount", 1);
    pushExpected("invOut1Seen", 0);
    pushExpected("mainIdle", 0);
    riseCnt = 0; flagA = 0; flagB = 0;
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      riseCnt += int'(invRise[0]);
      if (invOut[1]) flagA = 1;
      if (dout != 0) flagB = 1;
    end
    popCheck(invOut);
    popCheck(riseCnt);
    popCheck(flagA);
    popCheck(flagB);

    // Step response on channel 0
    applyStimulus(2'b01);
    pushExpected("stepLatencyOk", 1);
    pushExpected("stepRiseAtEdge", 1);
    pushExpected("stepRiseCount", 1);
    pushExpected("stepFallCount", 0);
    pushExpected("stepOut1Seen", 0);
    pushExpected("stepEvt", 2'b01);
    seen = 0; lat = 0; flagA = 0; flagB = 0; riseCnt = 0; fallCnt = 0;
    for (int c = 1; c <= 40; c++) begin
      stepCycle();
      if (!seen && dout[0]) begin
        seen  = 1;
        lat   = c;
        flagA = rise[0];
      end
      riseCnt += int'(rise[0]);
      fallCnt += int'(fall[0]);
      if (dout[1]) flagB = 1;
    end
    popCheck(seen && lat >= 12 && lat <= 16);
    popCheck(flagA);
    popCheck(riseCnt);
    popCheck(fallCnt);
    popCheck(flagB);
    popCheck(evt);

    // Release produces exactly one fall pulse
    applyStimulus(2'b00);
    pushExpected("relFallCount", 1);
    pushExpected("relOut", 0);
    fallCnt = 0;
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      fallCnt += int'(fall[0]);
    end
    popCheck(fallCnt);
    popCheck(dout);

    // Clear the sticky flags before the glitch test
    @(negedge clk);
    evtClr = 2'b11;
    @(negedge clk);
    evtClr = 2'b00;
    pushExpected("evtCleared", 0);
    popCheck(evt);

    // Glitch of 5 cycles is shorter than (N-1)*RATE and must be ignored
    applyStimulus(2'b01);
    repeat (5) @(negedge clk);
    pins = 2'b00;
    pushExpected("glitchOut", 0);
    pushExpected("glitchRise", 0);
    pushExpected("glitchEvt", 0);
    flagA = 0; riseCnt = 0; flagB = 0;
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      if (dout != 0) flagA = 1;
      riseCnt += int'(rise[0]);
      if (evt != 0) flagB = 1;
    end
    popCheck(flagA);
    popCheck(riseCnt);
    popCheck(flagB);

    // Sticky event on channel 1: set, then clear
    applyStimulus(2'b10);
    pushExpected("stickyRiseSeen", 1);
    pushExpected("stickyEvtSet", 1);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      stepCycle();
      if (rise[1]) seen = 1;
    end
    stepCycle();
    popCheck(seen);
    popCheck(evt[1]);
    @(negedge clk);
    evtClr = 2'b10;
    @(negedge clk);
    evtClr = 2'b00;
    pushExpected("stickyEvtClr", 0);
    popCheck(evt[1]);

    applyStimulus(2'b00);
    repeat (30) stepCycle();
    pushExpected("stickyRelOut", 0);
    popCheck(dout[1]);

    // Clear asserted in the very cycle the new rise pulse is high: set wins
    applyStimulus(2'b10);
    pushExpected("setWinsRiseSeen", 1);
    pushExpected("setWinsEvt", 1);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      stepCycle();
      if (rise[1]) begin
        seen   = 1;
        evtClr = 2'b10;
      end
    end
    stepCycle();
    evtClr = 2'b00;
    popCheck(seen);
    popCheck(evt[1]);

    // Long press on channel 0 (channel 1 stays held high)
    applyStimulus(2'b11);
    pushExpected("lpRiseSeen", 1);
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      stepCycle();
      if (rise[0]) seen = 1;
    end
    popCheck(seen);
`ifdef GPIO_DEBOUNCE_LONG_PRESS_EN
    pushExpected("lpLatencyOk", 1);
    seen2 = 0; lat = 0;
    for (int c = 1; c <= 30 && !seen2; c++) begin
      stepCycle();
      if (longPress[0]) begin
        seen2 = 1;
        lat   = c;
      end
    end
    popCheck(seen2 && lat >= 17 && lat <= 21);
    pushExpected("lpNoRepeat", 0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      stepCycle();
      cnt += int'(longPress[0]);
    end
    popCheck(cnt);
    applyStimulus(2'b10);
    repeat (30) stepCycle();
    pushExpected("lpRelOut", 0);
    popCheck(dout[0]);
    applyStimulus(2'b11);
    pushExpected("lpRepressCount", 1);
    cnt2 = 0;
    for (int c = 0; c < 60; c++) begin
      stepCycle();
      cnt2 += int'(longPress[0]);
    end
    popCheck(cnt2);
`else
    pushExpected("lpDisabled", 0);
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      stepCycle();
      cnt += int'(longPress != 0);
    end
    popCheck(cnt);
`endif

    // Asynchronous reset mid-operation with both outputs high
    pushExpected("preResetOut", 2'b11);
    popCheck(dout);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    pushExpected("asyncRstOut", 0);
    pushExpected("asyncRstEvt", 0);
    pushExpected("asyncRstLong", 0);
    popCheck(dout);
    popCheck(evt);
    popCheck(longPress);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pushExpected("postRstNoFall", 0);
    pushExpected("postRstLatencyOk", 1);
    pushExpected("postRstRiseBoth", 2'b11);
    seen = 0; lat = 0; fallCnt = 0; riseSnap = '0;
    for (int c = 1; c <= 40; c++) begin
      stepCycle();
      fallCnt += int'(fall != 0);
      if (!seen && rise != 0) begin
        seen     = 1;
        lat      = c;
        riseSnap = rise;
      end
    end
    popCheck(fallCnt);
    popCheck(seen && lat >= 12 && lat <= 16);
    popCheck(riseSnap);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_debounce_events.md
Name: gpio_debounce_events

Overview:
Parametrised successor to the board-level button/switch conditioning path, covering synchronise, debounce and per-channel event generation for WIDTH GPIO inputs. It sits between raw board pins and the core logic. It adds edge pulses, sticky event capture with clear, per-bit polarity inversion and optional long-press detection. One instance serves all buttons and switches of a board.

Parameters:
WIDTH, 8, number of input channels
SYNC_N, 2, synchroniser depth in flops (>=2)
N, 4, consecutive equal samples required to change a debounced level (>=2)
RATE, 125000, clk cycles per sample tick (>=1)
INVERT, {WIDTH{1'b0}}, per-bit mask; bit=1 inverts that input before sampling
LONG_TICKS, 2000, sample ticks of held-high level before a long_press pulse (1..65535)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in  input  WIDTH  raw asynchronous pin inputs
out  output  WIDTH  debounced level
rise  output  WIDTH  one-cycle pulse when out bit goes 0->1
fall  output  WIDTH  one-cycle pulse when out bit goes 1->0
evt  output  WIDTH  sticky rise-event flags
evt_clr  input  WIDTH  per-bit clear of evt (synchronous, level)
long_press  output  WIDTH  one-cycle pulse on long hold (0 when feature disabled)

Behaviour:
- Reset: asynchronous on reset_n low. All flops clear: synchroniser, prescaler, shift registers, out, rise, fall, evt, long_press and hold counters all 0. Release is synchronous to the next clk edge, with no pulses generated from pre-reset state.
- Synchroniser: SYNC_N-stage chain per bit. Stage input is in XOR INVERT.
- Prescaler: counter runs 0..RATE-1 and wraps to 0. tick=1 in the cycle where counter==RATE-1. With RATE=1, tick is always 1. Counter width is max(1,$clog2(RATE)).
- Sampling: on the edge ending a tick cycle, each channel's N-bit shift register shifts in the synchronised bit.
- Level decision, on the edge following a shift:
  - shift register all ones -> out bit goes to 1
  - shift register all zeros -> out bit goes to 0
  - otherwise -> out bit holds
- Edge pulses: rise/fall are registered on the same edge out changes. Each is exactly 1 cycle wide. A bit never has rise and fall high together.
- Latency from a stable input change to out: SYNC_N + (N-1)*RATE + 2 .. SYNC_N + N*RATE + 2 cycles.
- Glitch rejection: any pulse shorter than (N-1)*RATE cycles never changes out.
- evt: bit set on its rise pulse and cleared when evt_clr bit=1. If set and clear occur in the same cycle, set wins and the bit stays 1.
- Channels are fully independent; simultaneous events on multiple bits are all reported in the same cycle.

Optional Feature:
- Macro: GPIO_DEBOUNCE_LONG_PRESS_EN.
- With the macro defined:
  - Each channel has a 16-bit hold counter that clears when out=0 and increments on tick while out=1.
  - When the count reaches LONG_TICKS, long_press pulses for 1 cycle.
  - The counter then saturates, so there is no repeat until out returns to 0.
  - Reset mid-hold clears the counter and no pulse is emitted.
- Without the macro: long_press is tied to 0 and no hold counters are synthesised.

Decomposition:
- Shared package holds:
  - default constants: sync depth 2, hold counter width 16
  - a function computing prescaler width from RATE
- No typedefs needed.
- One natural sub-module, gpio_debounce_channel, instantiated per bit with generate. It contains the shift register, level decision, rise/fall, evt and the optional hold counter.
- The synchroniser and shared prescaler stay in the top.

Test Plan:
- Step response (WIDTH=2, SYNC_N=2, N=3, RATE=4): in[0] 0->1 held -> out[0] rises 12..16 cycles later. rise[0] is high exactly 1 cycle on that edge. fall and out[1] stay 0.
- Glitch rejection (same config): in[0] high for 5 cycles then low -> out, rise and evt remain 0 throughout.
- Sticky event: produce rise[1], then pulse evt_clr[1] -> evt[1]=0. Next, align evt_clr[1]=1 with a new rise[1] -> evt[1]=1 (set wins).
- Long press (macro on, LONG_TICKS=5, RATE=4): hold in[0] high -> long_press[0] pulses once 20 cycles after out[0] rises. No further pulse over 200 cycles of hold. Release and re-press -> pulses again.
- Reset mid-operation: with out=2'b11, drive reset_n low for 3 cycles -> out, evt and long_press are 0 immediately (asynchronous). After release with in held 1, no fall pulse, and rise fires after the full debounce latency.
- Inversion: INVERT=2'b01, in=2'b00 held from reset -> out=2'b01 after debounce, rise[0] pulses once, out[1] stays 0.
